// File: rtl/button_press_decoder_if.sv
// Button decoder bus: edge pulses in, rebuilt level and classified events out.
interface button_press_decoder_if;
    logic pressed;
    logic released;
    logic level;
    logic short_click;
    logic long_press;
    logic repeat_tick;
    logic protocol_err;

    modport master (
        output pressed,
        output released,
        input  level,
        input  short_click,
        input  long_press,
        input  repeat_tick,
        input  protocol_err
    );

    modport slave (
        input  pressed,
        input  released,
        output level,
        output short_click,
        output long_press,
        output repeat_tick,
        output protocol_err
    );
endinterface

// File: rtl/button_press_decoder.sv
// Rebuilds button level from press/release pulses and classifies short/long presses.
// Optional auto-repeat while long-held is enabled by defining BUTTON_REPEAT_EN.
module button_press_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    button_press_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Thresholds below 2 would make the terminal count collide with the reset value
    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_press_decoder: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_q, level_nxt;
    logic             short_q, short_nxt;
    logic             long_q, long_nxt;
    logic             rep_q, rep_nxt;
    logic             err_q, err_nxt;
    logic             both;

    assign both = bus.pressed & bus.released;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= level_nxt;
            short_q <= short_nxt;
            long_q  <= long_nxt;
            rep_q   <= rep_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next-state and next-output logic; release always beats a threshold on the same edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        rep_nxt   = 1'b0;
        err_nxt   = 1'b0;

        if (both) begin
            err_nxt = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.pressed) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (bus.released) begin
                        err_nxt = 1'b1;
                    end
                end
                HELD: begin
                    err_nxt = bus.pressed;
                    if (bus.released) begin
                        state_nxt = IDLE;
                        short_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end else if (cnt == LONG_LAST) begin
                        state_nxt = LONG;
                        long_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    err_nxt = bus.pressed;
                    if (bus.released) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
`ifdef BUTTON_REPEAT_EN
                        if (cnt == REPEAT_LAST) begin
                            rep_nxt = 1'b1;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
`else
                        cnt_nxt = '0;
`endif
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        level_nxt = (state_nxt != IDLE);
    end

    assign bus.level        = level_q;
    assign bus.short_click  = short_q;
    assign bus.long_press   = long_q;
    assign bus.repeat_tick  = rep_q;
    assign bus.protocol_err = err_q;

endmodule
